// File: rtl/unidade_controle_drone_if.sv
// Control/status bundle between the drone-game controller and its datapath.
// The master side is the controller: it reads the datapath flags and drives the control strobes.
interface unidade_controle_drone_if;
    logic       iniciar;
    logic       confirma;
    logic       colisao;
    logic       fim_espera;
    logic       fim_mapa;
    logic       escolhe_modo;
    logic       resetaVidas;
    logic       escolhe_vida;
    logic       zeraPosicoes;
    logic       zeraT;
    logic       contaT;
    logic       move_drone;
    logic       desloca_horizontal;
    logic       ganhou;
    logic       perdeu;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, confirma, colisao, fim_espera, fim_mapa,
        output escolhe_modo, resetaVidas, escolhe_vida, zeraPosicoes, zeraT,
               contaT, move_drone, desloca_horizontal, ganhou, perdeu, db_estado
    );

    modport slave (
        output iniciar, confirma, colisao, fim_espera, fim_mapa,
        input  escolhe_modo, resetaVidas, escolhe_vida, zeraPosicoes, zeraT,
               contaT, move_drone, desloca_horizontal, ganhou, perdeu, db_estado
    );
endinterface

// File: rtl/unidade_controle_drone.sv
// Moore FSM sequencing the drone-game datapath: mode/lives selection, then the timed
// move/shift/collision loop, ending in a win or loss state. Outputs are registered.
module unidade_controle_drone #(
    parameter int CONFIRMA_NIVEL = 0
) (
    input  logic                            clock,
    input  logic                            reset,
    unidade_controle_drone_if.master        bus
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        ESCOLHE_MODO  = 4'h1,
        PREPARA_VIDAS = 4'h2,
        ESCOLHE_VIDA  = 4'h3,
        PREPARACAO    = 4'h4,
        ESPERA        = 4'h5,
        DESLOCA       = 4'h6,
        AGUARDA_MAPA  = 4'h7,
        VERIFICA      = 4'h8,
        PERDEU        = 4'h9,
        GANHOU        = 4'hA
    } estado_t;

    typedef struct packed {
        logic escolhe_modo;
        logic resetaVidas;
        logic escolhe_vida;
        logic zeraPosicoes;
        logic zeraT;
        logic contaT;
        logic move_drone;
        logic desloca_horizontal;
        logic ganhou;
        logic perdeu;
    } saidas_t;

    estado_t estado_q, estado_d;
    saidas_t saidas_q, saidas_d;
    logic    confirma_q;
    logic    confirma_evt;

    function automatic saidas_t decodifica(estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            ESCOLHE_MODO:  s.escolhe_modo = 1'b1;
            PREPARA_VIDAS: s.resetaVidas  = 1'b1;
            ESCOLHE_VIDA:  s.escolhe_vida = 1'b1;
            PREPARACAO: begin
                s.zeraPosicoes = 1'b1;
                s.zeraT        = 1'b1;
            end
            ESPERA: begin
                s.contaT     = 1'b1;
                s.move_drone = 1'b1;
            end
            DESLOCA: begin
                s.desloca_horizontal = 1'b1;
                s.zeraT              = 1'b1;
            end
            PERDEU:  s.perdeu = 1'b1;
            GANHOU:  s.ganhou = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    // Edge mode fires once per press; a press held through reset release counts once.
    assign confirma_evt = bus.confirma & ((CONFIRMA_NIVEL != 0) ? 1'b1 : ~confirma_q);

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        estado_d = estado_q;
        case (estado_q)
            INICIAL:       if (bus.iniciar) estado_d = ESCOLHE_MODO;
            ESCOLHE_MODO:  if (confirma_evt) estado_d = PREPARA_VIDAS;
            PREPARA_VIDAS: estado_d = ESCOLHE_VIDA;
            ESCOLHE_VIDA:  if (confirma_evt) estado_d = PREPARACAO;
            PREPARACAO:    estado_d = ESPERA;
            ESPERA:        if (bus.fim_espera) estado_d = DESLOCA;
            DESLOCA:       estado_d = AGUARDA_MAPA;
            AGUARDA_MAPA:  estado_d = VERIFICA;
            VERIFICA: begin
                // Collision wins over end-of-map when both arrive together.
                if (bus.colisao)       estado_d = PERDEU;
                else if (bus.fim_mapa) estado_d = GANHOU;
                else                   estado_d = ESPERA;
            end
            PERDEU, GANHOU: if (bus.iniciar) estado_d = ESCOLHE_MODO;
            default:       estado_d = INICIAL;
        endcase
        // Decoding the next state keeps outputs registered yet aligned with estado_q.
        saidas_d = decodifica(estado_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            saidas_q   <= '0;
            confirma_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            estado_q   <= estado_d;
            saidas_q   <= saidas_d;
            confirma_q <= bus.confirma;
        end
    end

    assign bus.escolhe_modo       = saidas_q.escolhe_modo;
    assign bus.resetaVidas        = saidas_q.resetaVidas;
    assign bus.escolhe_vida       = saidas_q.escolhe_vida;
    assign bus.zeraPosicoes       = saidas_q.zeraPosicoes;
    assign bus.zeraT              = saidas_q.zeraT;
    assign bus.contaT             = saidas_q.contaT;
    assign bus.move_drone         = saidas_q.move_drone;
    assign bus.desloca_horizontal = saidas_q.desloca_horizontal;
    assign bus.ganhou             = saidas_q.ganhou;
    assign bus.perdeu             = saidas_q.perdeu;
    assign bus.db_estado          = estado_q;

endmodule

// File: tb/tb_unidade_controle_drone.sv
// Directed bench for the drone-game controller: walks every state, the loop, both end
// states, collision-over-win priority and an asynchronous mid-game reset.
module tb_unidade_controle_drone;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    unidade_controle_drone_if bus ();

    unidade_controle_drone #(.CONFIRMA_NIVEL(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // {escolhe_modo, resetaVidas, escolhe_vida, zeraPosicoes, zeraT,
    //  contaT, move_drone, desloca_horizontal, ganhou, perdeu}
    logic [9:0] saidas;
    assign saidas = {bus.escolhe_modo, bus.resetaVidas, bus.escolhe_vida, bus.zeraPosicoes,
                     bus.zeraT, bus.contaT, bus.move_drone, bus.desloca_horizontal,
                     bus.ganhou, bus.perdeu};

    function automatic logic [9:0] saidas_esperadas(logic [3:0] e);
        case (e)
            4'h1:    return 10'b10_0000_0000;
            4'h2:    return 10'b01_0000_0000;
            4'h3:    return 10'b00_1000_0000;
            4'h4:    return 10'b00_0110_0000;
            4'h5:    return 10'b00_0001_1000;
            4'h6:    return 10'b00_0010_0100;
            4'h9:    return 10'b00_0000_0001;
            4'hA:    return 10'b00_0000_0010;
            default: return 10'b00_0000_0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock, then compare state and all outputs against the table.
    task automatic step(input logic [3:0] e);
        @(posedge clock);
        #1;
        check("estado", 32'(bus.db_estado), 32'(e));
        check("saidas", 32'(saidas), 32'(saidas_esperadas(e)));
    endtask

    // From escolhe_modo: select mode, select lives, land in espera.
    task automatic ate_espera();
        bus.confirma = 1'b1;
        step(4'h2);
        step(4'h3);
        bus.confirma = 1'b0;
        step(4'h3);
        bus.confirma = 1'b1;
        step(4'h4);
        bus.confirma = 1'b0;
        step(4'h5);
    endtask

    // From espera: one column shift up to verifica.
    task automatic ate_verifica();
        bus.fim_espera = 1'b1;
        step(4'h6);
        bus.fim_espera = 1'b0;
        step(4'h7);
        step(4'h8);
    endtask

    initial begin
        bus.iniciar    = 1'b0;
        bus.confirma   = 1'b0;
        bus.colisao    = 1'b0;
        bus.fim_espera = 1'b0;
        bus.fim_mapa   = 1'b0;

        #12;
        check("reset_estado", 32'(bus.db_estado), 32'h0);
        check("reset_saidas", 32'(saidas), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) step(4'h0);

        bus.iniciar = 1'b1;
        step(4'h1);
        bus.iniciar = 1'b0;

        // confirma held 4 cycles: a single transition, then escolhe_vida holds.
        bus.confirma = 1'b1;
        step(4'h2);
        step(4'h3);
        step(4'h3);
        step(4'h3);
        bus.confirma = 1'b0;
        step(4'h3);
        bus.confirma = 1'b1;
        step(4'h4);
        bus.confirma = 1'b0;
        step(4'h5);

        for (int i = 0; i < 10; i++) step(4'h5);

        // iniciar is ignored while the game loop runs.
        bus.iniciar = 1'b1;
        ate_verifica();
        bus.iniciar = 1'b0;
        step(4'h5);

        // Collision and end-of-map together: loss.
        ate_verifica();
        bus.colisao  = 1'b1;
        bus.fim_mapa = 1'b1;
        step(4'h9);
        bus.colisao  = 1'b0;
        bus.fim_mapa = 1'b0;
        step(4'h9);
        bus.iniciar = 1'b1;
        step(4'h1);
        bus.iniciar = 1'b0;

        // End of map without collision: win, held until iniciar.
        ate_espera();
        ate_verifica();
        bus.fim_mapa = 1'b1;
        step(4'hA);
        bus.fim_mapa = 1'b0;
        step(4'hA);
        step(4'hA);
        bus.iniciar = 1'b1;
        step(4'h1);
        bus.iniciar = 1'b0;

        // Asynchronous reset in the middle of espera.
        ate_espera();
        #3;
        reset = 1'b0;
        #1;
        check("async_estado", 32'(bus.db_estado), 32'h0);
        check("async_contaT", 32'(bus.contaT), 32'h0);
        check("async_saidas", 32'(saidas), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        step(4'h0);
        step(4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidade_controle_drone.md
Name: unidade_controle_drone

Overview:
- Moore FSM that sequences the drone-game datapath (`fluxo_dados`).
- Covers mode selection, lives selection, position/timer preparation, and the timed move/shift/collision loop.
- Terminates in a win or loss state.
- Sits beside `fluxo_dados` in the top level: consumes its status flags and drives its control strobes.

Parameters:
- CONFIRMA_NIVEL, 0, 0 = `confirma` acts on its rising edge (internal detector); 1 = `confirma` acts on level.

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low; forces state inicial
- iniciar  input  1  start/restart request, level
- confirma  input  1  confirm button, raw level
- colisao  input  1  datapath collision flag (lives exhausted)
- fim_espera  input  1  move-window timer expired for current mode
- fim_mapa  input  1  horizontal counter at last column
- escolhe_modo  output  1  enables mode counter
- resetaVidas  output  1  loads lives counter to 1
- escolhe_vida  output  1  enables lives counter
- zeraPosicoes  output  1  reloads horizontal/vertical/collision counters
- zeraT  output  1  synchronous clear of move timers
- contaT  output  1  move timers count
- move_drone  output  1  vertical moves accepted
- desloca_horizontal  output  1  advance map one column
- ganhou  output  1  win indicator
- perdeu  output  1  loss indicator
- db_estado  output  4  current state code

Behaviour:
- State register resets asynchronously to inicial when reset=0.
- All outputs are decoded from the state only (Moore). Reset values: all strobes 0, ganhou=0, perdeu=0, db_estado=4'h0.
- Confirm event:
  - CONFIRMA_NIVEL=0: event = confirma & ~confirma_q, where confirma_q is a register reset to 0. Consequence: confirma held high through reset release yields one event in the first cycle.
  - CONFIRMA_NIVEL=1: event = confirma.
- States (code; asserted outputs; transitions):
  - inicial (0x0): none. iniciar=1 -> escolhe_modo, else stay.
  - escolhe_modo (0x1): escolhe_modo. Confirm event -> prepara_vidas.
  - prepara_vidas (0x2): resetaVidas. Unconditional -> escolhe_vida.
  - escolhe_vida (0x3): escolhe_vida. Confirm event -> preparacao.
  - preparacao (0x4): zeraPosicoes, zeraT. Unconditional -> espera.
  - espera (0x5): contaT, move_drone. fim_espera=1 -> desloca, else stay.
  - desloca (0x6): desloca_horizontal, zeraT. Unconditional -> aguarda_mapa.
  - aguarda_mapa (0x7): none; covers the one-cycle synchronous map-RAM read latency after the column advance. Unconditional -> verifica.
  - verifica (0x8): none. colisao=1 -> perdeu; else fim_mapa=1 -> ganhou; else -> espera.
  - perdeu (0x9): perdeu. iniciar=1 -> escolhe_modo.
  - ganhou (0xA): ganhou. iniciar=1 -> escolhe_modo.
  - Codes 0xB-0xF are illegal and go -> inicial on the next clock.
- Priority: in verifica, collision beats end-of-map when both are set in the same cycle (loss).
- No path exists to the end states except through verifica. iniciar is ignored in states 0x1-0x8.
- Each single-cycle strobe (resetaVidas, zeraPosicoes, desloca_horizontal) is high for exactly one clock per pass.
- Timing: from the cycle fim_espera is sampled high, the map shift happens on the next edge, and the decision in verifica comes 3 clocks after leaving espera.
- Reset asserted mid-game: immediate return to inicial, all outputs 0. After release, wait for iniciar.

Test Plan:
- Reset low, then high, all inputs 0 -> db_estado=0x0 and all outputs 0 for 5 clocks; iniciar=1 for 1 cycle -> db_estado=0x1, escolhe_modo=1.
- In 0x1, confirma held high 4 cycles (CONFIRMA_NIVEL=0) -> one transition only: 0x2 (resetaVidas for 1 clock), then 0x3 held. Second confirma rise -> 0x4 then 0x5, with zeraPosicoes=zeraT=1 exactly one cycle.
- In 0x5, fim_espera=0 for 10 cycles -> stays 0x5 with contaT=move_drone=1. fim_espera=1 -> 0x6, 0x7, 0x8; colisao=fim_mapa=0 -> back to 0x5, desloca_horizontal pulsed once.
- In 0x8, colisao=1 and fim_mapa=1 together -> 0x9, perdeu=1, ganhou=0; iniciar=1 -> 0x1.
- In 0x8, colisao=0 and fim_mapa=1 -> 0xA, ganhou=1 held until iniciar=1.
- Reset pulled low asynchronously mid-clock while in 0x5 -> db_estado=0x0 and contaT=0 before the next rising edge.
